// File: rtl/spiflash_fetch_arbiter.sv
// Two-port read arbiter for a SPI NOR flash (READ 0x03, mode 0).
// Non-sequential reads issue the full command; sequential reads stream one more byte with CS held low.
module spiflash_fetch_arbiter #(
  parameter int AW          = 12,
  parameter int HALF_PERIOD = 2,
  parameter int CS_GAP      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          double_speed,
  input  logic          flush,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack1,
  output logic [7:0]    rdata,
  output logic          busy,
  output logic          spi_cs_n,
  output logic          spi_sclk,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  typedef enum logic [2:0] {IDLE, GAP, CMD, DATA, DONE} state_e;

  state_e        state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          stream_valid_q, stream_valid_d;
  logic          last_grant_q, last_grant_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          port_q, port_d;
  logic          fast_q, fast_d;
  logic          flush_pend_q, flush_pend_d;
  logic [31:0]   cmd_q, cmd_d;
  logic [7:0]    rx_q, rx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;

  logic          sel;
  logic [AW-1:0] sel_addr;
  logic          seq;
  logic          half_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      rdata_q        <= '0;
      stream_valid_q <= 1'b0;
      last_grant_q   <= 1'b1;
      last_addr_q    <= '0;
      addr_q         <= '0;
      port_q         <= 1'b0;
      fast_q         <= 1'b0;
      flush_pend_q   <= 1'b0;
      cmd_q          <= '0;
      rx_q           <= '0;
      cnt_q          <= '0;
      bit_q          <= '0;
    end else begin
      state_q        <= state_d;
      cs_n_q         <= cs_n_d;
      sclk_q         <= sclk_d;
      mosi_q         <= mosi_d;
      rdata_q        <= rdata_d;
      stream_valid_q <= stream_valid_d;
      last_grant_q   <= last_grant_d;
      last_addr_q    <= last_addr_d;
      addr_q         <= addr_d;
      port_q         <= port_d;
      fast_q         <= fast_d;
      flush_pend_q   <= flush_pend_d;
      cmd_q          <= cmd_d;
      rx_q           <= rx_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cs_n_d         = cs_n_q;
    sclk_d         = sclk_q;
    mosi_d         = mosi_q;
    rdata_d        = rdata_q;
    stream_valid_d = stream_valid_q;
    last_grant_d   = last_grant_q;
    last_addr_d    = last_addr_q;
    addr_d         = addr_q;
    port_d         = port_q;
    fast_d         = fast_q;
    flush_pend_d   = flush_pend_q;
    cmd_d          = cmd_q;
    rx_d           = rx_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;

    sel       = (req0 && req1) ? ~last_grant_q : req1;
    sel_addr  = sel ? addr1 : addr0;
    // The extra top bit keeps all-ones + 1 from wrapping onto address 0.
    seq       = stream_valid_q && !flush && !cs_n_q &&
                ({1'b0, sel_addr} == ({1'b0, last_addr_q} + (AW+1)'(1)));
    half_last = fast_q || (cnt_q == 16'(HALF_PERIOD - 1));

    case (state_q)
      IDLE: begin
        if (flush) cs_n_d = 1'b1;
        if (req0 || req1) begin
          port_d       = sel;
          addr_d       = sel_addr;
          fast_d       = double_speed;
          flush_pend_d = 1'b0;
          cnt_d        = '0;
          bit_d        = '0;
          cmd_d        = {8'h03, 24'(sel_addr)};
          sclk_d       = 1'b0;
          if (seq) begin
            state_d = DATA;
            mosi_d  = 1'b0;
          end else begin
            state_d = GAP;
            cs_n_d  = 1'b1;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CS_GAP - 1)) begin
          state_d = CMD;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          mosi_d  = cmd_q[31];
          cmd_d   = {cmd_q[30:0], 1'b0};
        end
      end
      CMD, DATA: begin
        if (!half_last) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (state_q == DATA) rx_d = {rx_q[6:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
            if (state_q == CMD) begin
              if (bit_q == 5'd31) begin
                state_d = DATA;
                bit_d   = '0;
                mosi_d  = 1'b0;
              end else begin
                mosi_d = cmd_q[31];
                cmd_d  = {cmd_q[30:0], 1'b0};
              end
            end else if (bit_q == 5'd7) begin
              state_d = DONE;
              rdata_d = rx_q;
            end
          end
        end
      end
      DONE: begin
        state_d        = IDLE;
        last_addr_d    = addr_q;
        last_grant_d   = port_q;
        stream_valid_d = !flush_pend_q;
        flush_pend_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // A flush seen mid-transaction must also outlive the DONE that would re-arm streaming.
    if (flush) begin
      stream_valid_d = 1'b0;
      if (state_q != IDLE && state_q != DONE) flush_pend_d = 1'b1;
    end
  end

  assign ack0     = (state_q == DONE) && !port_q;
  assign ack1     = (state_q == DONE) &&  port_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spiflash_fetch_arbiter.sv
// Directed bench for spiflash_fetch_arbiter with a behavioural SPI flash model.
module tb_spiflash_fetch_arbiter;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          double_speed = 1'b0;
  logic          flush = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          ack0, ack1, busy;
  logic [7:0]    rdata;
  logic          spi_cs_n, spi_sclk, spi_mosi;
  logic          spi_miso = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spiflash_fetch_arbiter #(.AW(AW), .HALF_PERIOD(2), .CS_GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .double_speed(double_speed), .flush(flush),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // Flash model: 4 KiB array, READ command, auto-incrementing byte stream while CS stays low.
  logic [7:0]  mem [0:4095];
  logic [31:0] fcmd = '0;
  logic [11:0] faddr = '0;
  logic [7:0]  byte_t;
  int fbits = 0, fdbit = 0, frame_id = 0;
  int sclk_rises = 0, cs_rises = 0;

  always @(posedge spi_cs_n) cs_rises++;

  always @(posedge spi_sclk) begin
    sclk_rises++;
    if (!spi_cs_n) begin
      if (frame_id != cs_rises) begin
        frame_id = cs_rises;
        fbits    = 0;
        fdbit    = 0;
      end
      if (fbits < 32) begin
        fcmd = {fcmd[30:0], spi_mosi};
        fbits++;
        if (fbits == 32) begin
          faddr = fcmd[11:0];
          fdbit = 0;
        end
      end else begin
        fdbit++;
        if (fdbit == 8) begin
          fdbit = 0;
          faddr = faddr + 12'd1;
        end
      end
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_cs_n && fbits == 32 && frame_id == cs_rises) begin
      byte_t   = mem[faddr];
      spi_miso = byte_t[3'(7 - fdbit)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cs_high;
  int d_sclk, d_cs;

  task automatic do_read(input logic port, input logic [AW-1:0] a, input logic ds,
                         output int cyc, output logic [7:0] data);
    int n, s0, c0;
    double_speed = ds;
    if (port) begin req1 = 1'b1; addr1 = a; end
    else      begin req0 = 1'b1; addr0 = a; end
    s0 = sclk_rises; c0 = cs_rises; cs_high = 0;
    cyc = -1; data = '0; n = 0;
    while (n < 400 && cyc < 0) begin
      @(negedge clk);
      n++;
      if (spi_cs_n) cs_high++;
      if ((port ? ack1 : ack0) === 1'b1) begin
        cyc  = n;
        data = rdata;
      end
    end
    d_sclk = sclk_rises - s0;
    d_cs   = cs_rises - c0;
    req0 = 1'b0; req1 = 1'b0; double_speed = 1'b0;
    @(negedge clk);
    chk("ack_pulse", {31'd0, ack0 | ack1}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic port, input logic [AW-1:0] a, input logic ds,
                    input int exp_cyc, input logic full_cmd);
    int cyc;
    logic [7:0] data;
    do_read(port, a, ds, cyc, data);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_rdata"}, {24'd0, data}, {24'd0, mem[a]});
    if (full_cmd) chk({tag, "_cmd"}, fcmd, {8'h03, 12'h000, a});
  endtask

  task automatic tie(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic first1);
    int n, c0, c1, p0, p1;
    logic [7:0] d0, d1;
    c0 = -1; c1 = -1; p0 = 0; p1 = 0; d0 = '0; d1 = '0; n = 0;
    addr0 = a0; addr1 = a1; req0 = 1'b1; req1 = 1'b1;
    while (n < 800 && (c0 < 0 || c1 < 0)) begin
      @(negedge clk);
      n++;
      if (ack0 === 1'b1) begin p0++; if (c0 < 0) begin c0 = n; d0 = rdata; end req0 = 1'b0; end
      if (ack1 === 1'b1) begin p1++; if (c1 < 0) begin c1 = n; d1 = rdata; end req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, ack0 | ack1}, 32'd0);
    chk({tag, "_ack0_cycle"}, 32'(c0), first1 ? 32'd325 : 32'd162);
    chk({tag, "_ack1_cycle"}, 32'(c1), first1 ? 32'd162 : 32'd325);
    chk({tag, "_rdata0"}, {24'd0, d0}, {24'd0, mem[a0]});
    chk({tag, "_rdata1"}, {24'd0, d1}, {24'd0, mem[a1]});
    chk({tag, "_ack0_width"}, 32'(p0), 32'd1);
    chk({tag, "_ack1_width"}, 32'(p1), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stuck;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[12'h123] = 8'hA5;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_ack",  {30'd0, ack1, ack0}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    rd("cold", 1'b0, 12'h123, 1'b0, 162, 1'b1);
    chk("cold_cs_high", 32'(cs_high), 32'd1);

    rd("seq", 1'b0, 12'h124, 1'b0, 33, 1'b0);
    chk("seq_sclk_pulses", 32'(d_sclk), 32'd8);
    chk("seq_cs_rises", 32'(d_cs), 32'd0);
    chk("seq_cs_high", 32'(cs_high), 32'd0);

    rd("jump", 1'b0, 12'h200, 1'b0, 162, 1'b1);
    chk("jump_cs_high", 32'(cs_high), 32'd1);
    chk("jump_cs_rises", 32'(d_cs), 32'd1);
    chk("jump_sclk_pulses", 32'(d_sclk), 32'd40);

    rd("wrap_hi", 1'b0, 12'hFFF, 1'b0, 162, 1'b1);
    rd("wrap_lo", 1'b0, 12'h000, 1'b0, 162, 1'b1);

    rd("fast", 1'b0, 12'h555, 1'b1, 82, 1'b1);

    rd("pre_flush", 1'b0, 12'h400, 1'b0, 162, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_cs_n", {31'd0, spi_cs_n}, 32'd1);
    rd("post_flush", 1'b0, 12'h401, 1'b0, 162, 1'b1);

    fork
      rd("busy_flush", 1'b1, 12'h300, 1'b0, 162, 1'b1);
      begin
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    rd("after_busy_flush", 1'b1, 12'h301, 1'b0, 162, 1'b1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tie("tie_a", 12'h310, 12'h520, 1'b0);
    rd("solo", 1'b0, 12'h600, 1'b0, 162, 1'b1);
    tie("tie_b", 12'h7A0, 12'h700, 1'b1);

    rd("pre_abort", 1'b0, 12'h040, 1'b0, 162, 1'b1);
    stuck = 0;
    addr0 = 12'h080; req0 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ack0 === 1'b1) stuck++;
    end
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    if (ack0 === 1'b1) stuck++;
    @(negedge clk);
    if (ack0 === 1'b1) stuck++;
    chk("abort_no_ack", 32'(stuck), 32'd0);
    rst_n = 1'b1;
    rd("after_abort", 1'b0, 12'h041, 1'b0, 162, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
